regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port (RegWrite / write_reg / write_data) between two requesters.
  - Port A: core writeback, single-cycle ALU/load path.
  - Port B: long-latency unit, e.g. mult/div result.
- Port B results are buffered in a small FIFO and drained when A is idle. A starvation limit and a WAW rule force a drain.
- Exposes pending-write hit flags so decode can stall on reads of a register whose B-write is still queued.
- Sits between the execute/writeback stage and the register file.

---
 rtl/regfile_write_arbiter_pkg.sv | 15 +
 rtl/regfile_write_arbiter_if.sv | 37 +++
 rtl/regfile_write_arbiter_wb_fifo.sv | 65 ++++++
 rtl/regfile_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared writeback types and constants for the register-file write path.
// No logic; latency and backpressure are defined by the modules that use it.
package mips_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bundle: core port A, long-latency port B, decode hit lookup, regfile write port.
// Combinational through the arbiter; A stalls on a_ready, B stalls on b_ready.
interface regfile_write_arbiter_if #(
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int DATA_W = mips_pkg::DATA_W
);

  logic              a_valid;
  logic [ADDR_W-1:0] a_reg;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;

  logic              b_valid;
  logic [ADDR_W-1:0] b_reg;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  logic [ADDR_W-1:0] read_reg_1;
  logic [ADDR_W-1:0] read_reg_2;
  logic              pend_hit_1;
  logic              pend_hit_2;

  logic              RegWrite;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data, read_reg_1, read_reg_2,
    input  a_ready, b_ready, pend_hit_1, pend_hit_2, RegWrite, write_reg, write_data
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, read_reg_1, read_reg_2,
    output a_ready, b_ready, pend_hit_1, pend_hit_2, RegWrite, write_reg, write_data
  );

endinterface

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// In-order FIFO of pending long-latency writebacks with every slot and its valid bit visible.
// Push visible at head one cycle later; caller must not push when full nor pop when empty.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_req_t
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_vld,
  input  entry_t             push_dat,
  input  logic               pop_vld,
  output entry_t             head_dat,
  output entry_t             ent_dat [DEPTH],
  output logic [DEPTH-1:0]   ent_vld,
  output logic               empty,
  output logic               full
);

  localparam int AW = $clog2(DEPTH);

  // Extra wrap bit separates full from empty when the indices coincide.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;
  entry_t        mem [DEPTH];

  assign wr_idx  = wr_ptr[AW-1:0];
  assign rd_idx  = rd_ptr[AW-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign do_push = push_vld && !full;
  assign do_pop  = pop_vld && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ent_vld <= '0;
    end else begin
      if (do_push) begin
        wr_ptr          <= wr_ptr + (AW+1)'(1);
        ent_vld[wr_idx] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr          <= rd_ptr + (AW+1)'(1);
        ent_vld[rd_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_dat;
    end
  end

  assign head_dat = mem[rd_idx];
  assign ent_dat  = mem;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between core writeback (A) and a queued long-latency port (B).
// Write port is combinational; A stalls via a_ready on forced drains, B stalls via b_ready when full.
module regfile_write_arbiter #(
  parameter int DEPTH      = 2,
  parameter int ADDR_W     = mips_pkg::ADDR_W,
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_write_arbiter_if.slave bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT_A,
    ARB_DRAIN_B,
    ARB_FORCE_B
  } arb_t;

  localparam int                CW   = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(mips_pkg::REG_ZERO);

  arb_t             sel;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  req_t             push_req;
  req_t             head;
  req_t             ent [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic             waw;
  logic             hit_1;
  logic             hit_2;
  logic             starved;
  logic [CW-1:0]    starve_cnt;
  logic [CW-1:0]    starve_nxt;
  req_t             wr_req;

  assign push_req    = '{reg_addr: bus.b_reg, data: bus.b_data};
  assign bus.b_ready = rst_n && !full;
  assign push        = bus.b_valid && bus.b_ready;

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (req_t)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push),
    .push_dat (push_req),
    .pop_vld  (pop),
    .head_dat (head),
    .ent_dat  (ent),
    .ent_vld  (ent_vld),
    .empty    (empty),
    .full     (full)
  );

  // Entry being popped this cycle still counts as a hit: decode stalls one cycle extra, never too few.
  always_comb begin
    waw   = 1'b0;
    hit_1 = 1'b0;
    hit_2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) begin
        if (ent[i].reg_addr == bus.a_reg)      waw   = 1'b1;
        if (ent[i].reg_addr == bus.read_reg_1) hit_1 = 1'b1;
        if (ent[i].reg_addr == bus.read_reg_2) hit_2 = 1'b1;
      end
    end
  end

  assign bus.pend_hit_1 = rst_n && hit_1 && (bus.read_reg_1 != ZERO);
  assign bus.pend_hit_2 = rst_n && hit_2 && (bus.read_reg_2 != ZERO);

  assign starved = (starve_cnt == CW'(STARVE_MAX));

  always_comb begin
    sel = ARB_IDLE;
    if (!rst_n) begin
      sel = ARB_IDLE;
    end else if (!empty && (starved || (bus.a_valid && waw))) begin
      sel = ARB_FORCE_B;
    end else if (bus.a_valid) begin
      sel = ARB_GRANT_A;
    end else if (!empty) begin
      sel = ARB_DRAIN_B;
    end
  end

  always_comb begin
    pop         = 1'b0;
    bus.a_ready = rst_n;
    wr_req      = '0;
    case (sel)
      ARB_FORCE_B: begin
        pop         = 1'b1;
        bus.a_ready = 1'b0;
        wr_req      = head;
      end
      ARB_GRANT_A: begin
        wr_req = '{reg_addr: bus.a_reg, data: bus.a_data};
      end
      ARB_DRAIN_B: begin
        pop    = 1'b1;
        wr_req = head;
      end
      default: begin
        wr_req = '0;
      end
    endcase
  end

  // $0 writes still complete their handshake; only the regfile enable is suppressed.
  assign bus.RegWrite   = (sel != ARB_IDLE) && (wr_req.reg_addr != ZERO);
  assign bus.write_reg  = wr_req.reg_addr;
  assign bus.write_data = wr_req.data;

  always_comb begin
    starve_nxt = starve_cnt;
    if (empty || pop) begin
      starve_nxt = '0;
    end else if (!starved) begin
      starve_nxt = starve_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: stimulus pushes expected regfile writes; a negedge monitor pops and compares.
module tb_regfile_write_arbiter;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  wr_t  exp_q [$];
  bit   starve_rdy [10] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1};

  regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_write_arbiter #(
    .DEPTH      (2),
    .ADDR_W     (5),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expw(input logic [4:0] r, input logic [31:0] d);
    wr_t w;
    w.r = r;
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.a_valid    = 1'b0;
    bus.a_reg      = '0;
    bus.a_data     = '0;
    bus.b_valid    = 1'b0;
    bus.b_reg      = '0;
    bus.b_data     = '0;
    bus.read_reg_1 = '0;
    bus.read_reg_2 = '0;
  endtask

  task automatic drive_a(input logic [4:0] r, input logic [31:0] d);
    bus.a_valid = 1'b1;
    bus.a_reg   = r;
    bus.a_data  = d;
  endtask

  task automatic drive_b(input logic [4:0] r, input logic [31:0] d);
    bus.b_valid = 1'b1;
    bus.b_reg   = r;
    bus.b_data  = d;
  endtask

  // Monitor: every write the regfile would capture must match the next expected one.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.RegWrite) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got r%0d=%0h expected none", bus.write_reg, bus.write_data);
        end else begin
          e = exp_q.pop_front();
          check("write", {bus.write_reg, bus.write_data}, {e.r, e.d});
        end
      end
    end
  end

  initial begin
    logic [4:0] cur;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    clr();

    // Reset: outputs quiet even with requests present
    drive_a(5'd3, 32'h3);
    drive_b(5'd4, 32'h4);
    #2;
    check("rst_regwrite", bus.RegWrite, 0);
    check("rst_a_ready", bus.a_ready, 0);
    check("rst_b_ready", bus.b_ready, 0);
    check("rst_pend_hit_1", bus.pend_hit_1, 0);
    repeat (2) cyc();
    clr();
    rst_n = 1'b1;
    #1;
    check("post_rst_b_ready", bus.b_ready, 1);
    check("post_rst_a_ready", bus.a_ready, 1);
    check("post_rst_regwrite", bus.RegWrite, 0);

    // Single B push, drained next cycle, hit only while queued
    cyc();
    drive_b(5'd8, 32'hDEAD_BEEF);
    bus.read_reg_1 = 5'd8;
    #1;
    check("t1_no_bypass", bus.RegWrite, 0);
    check("t1_hit_before", bus.pend_hit_1, 0);
    expw(5'd8, 32'hDEAD_BEEF);
    cyc();
    bus.b_valid = 1'b0;
    #1;
    check("t1_drain_regwrite", bus.RegWrite, 1);
    check("t1_hit_queued", bus.pend_hit_1, 1);
    check("t1_a_ready", bus.a_ready, 1);
    cyc();
    #1;
    check("t1_hit_after", bus.pend_hit_1, 0);
    check("t1_idle", bus.RegWrite, 0);

    // Starvation: A busy, r10 forced out after 4 grants
    cur = 5'd1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      clr();
      drive_a(cur, 32'h100 + 32'(cur));
      if (c == 0) drive_b(5'd10, 32'hA0A0);
      #1;
      check("t2_a_ready", bus.a_ready, 64'(starve_rdy[c]));
      if (starve_rdy[c]) begin
        expw(cur, 32'h100 + 32'(cur));
        cur = cur + 5'd1;
      end else begin
        expw(5'd10, 32'hA0A0);
      end
    end
    cyc();
    clr();
    #1;
    check("t2_idle", bus.RegWrite, 0);

    // WAW: queued r5 must reach the regfile before A's r5
    cyc();
    drive_b(5'd5, 32'h11);
    cyc();
    clr();
    drive_a(5'd5, 32'h22);
    #1;
    check("t3_force_a_ready", bus.a_ready, 0);
    expw(5'd5, 32'h11);
    cyc();
    #1;
    check("t3_grant_a_ready", bus.a_ready, 1);
    expw(5'd5, 32'h22);
    cyc();
    clr();

    // Fill to full while A busy, then drain in push order
    drive_a(5'd11, 32'h211);
    drive_b(5'd20, 32'h320);
    #1;
    check("t4_c0_b_ready", bus.b_ready, 1);
    expw(5'd11, 32'h211);
    cyc();
    drive_a(5'd12, 32'h212);
    drive_b(5'd21, 32'h321);
    #1;
    check("t4_c1_b_ready", bus.b_ready, 1);
    expw(5'd12, 32'h212);
    cyc();
    drive_a(5'd13, 32'h213);
    drive_b(5'd22, 32'h322);
    bus.read_reg_1 = 5'd21;
    bus.read_reg_2 = 5'd22;
    #1;
    check("t4_full_b_ready", bus.b_ready, 0);
    check("t4_hit_21", bus.pend_hit_1, 1);
    check("t4_hit_22_absent", bus.pend_hit_2, 0);
    expw(5'd13, 32'h213);
    cyc();
    bus.a_valid = 1'b0;
    #1;
    check("t4_pop_no_free", bus.b_ready, 0);
    expw(5'd20, 32'h320);
    cyc();
    #1;
    check("t4_freed_b_ready", bus.b_ready, 1);
    expw(5'd21, 32'h321);
    cyc();
    bus.b_valid = 1'b0;
    #1;
    check("t4_hit_22_queued", bus.pend_hit_2, 1);
    expw(5'd22, 32'h322);
    cyc();
    #1;
    check("t4_empty_regwrite", bus.RegWrite, 0);
    check("t4_empty_hit", bus.pend_hit_2, 0);
    clr();

    // $0 from A and B: handshakes complete, no write, no hit
    cyc();
    drive_a(5'd0, 32'h5);
    drive_b(5'd0, 32'h77);
    #1;
    check("t5_a_ready", bus.a_ready, 1);
    check("t5_a_regwrite", bus.RegWrite, 0);
    check("t5_b_ready", bus.b_ready, 1);
    cyc();
    bus.a_valid = 1'b0;
    drive_b(5'd3, 32'h33);
    #1;
    check("t5_b_regwrite", bus.RegWrite, 0);
    check("t5_hit_zero", bus.pend_hit_1, 0);
    cyc();
    bus.b_valid    = 1'b0;
    bus.read_reg_2 = 5'd3;
    #1;
    check("t5_hit_zero_2", bus.pend_hit_1, 0);
    check("t5_hit_r3", bus.pend_hit_2, 1);
    expw(5'd3, 32'h33);
    cyc();
    clr();

    // Async reset with two entries queued: no stale write afterwards
    drive_a(5'd1, 32'h401);
    drive_b(5'd24, 32'h524);
    #1;
    expw(5'd1, 32'h401);
    cyc();
    drive_a(5'd2, 32'h402);
    drive_b(5'd25, 32'h525);
    #1;
    expw(5'd2, 32'h402);
    cyc();
    clr();
    bus.read_reg_1 = 5'd25;
    #1;
    check("t6_pre_rst_regwrite", bus.RegWrite, 1);
    check("t6_pre_rst_hit", bus.pend_hit_1, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_regwrite", bus.RegWrite, 0);
    check("t6_rst_a_ready", bus.a_ready, 0);
    check("t6_rst_b_ready", bus.b_ready, 0);
    check("t6_rst_hit", bus.pend_hit_1, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    #1;
    check("t6_post_hit", bus.pend_hit_1, 0);
    check("t6_post_b_ready", bus.b_ready, 1);
    for (int c = 0; c < 3; c++) begin
      cyc();
      #1;
      check("t6_no_stale", bus.RegWrite, 0);
    end

    cyc();
    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
